// File: rtl/lpif_quarter_pkg.sv
// Shared slot geometry and FSM encoding for the quarter-rate downstream packer.
package lpif_quarter_pkg;

  localparam int SLOTS         = 4;
  localparam int SLOT_IDX_W    = 2;
  localparam int SLOT_DATA_W   = 256;
  localparam int SLOT_STATE_W  = 4;
  localparam int SLOT_PROTID_W = 2;
  localparam int SLOT_CRC_W    = 16;

  typedef enum logic [1:0] {
    ST_OFFLINE = 2'd0,
    ST_IDLE    = 2'd1,
    ST_FILL    = 2'd2
  } pack_state_e;

  // LSB-contiguous valid mask for a bundle holding 'filled' slots (0 means all four).
  function automatic logic [SLOTS-1:0] fill_mask(input logic [SLOT_IDX_W-1:0] filled);
    logic [SLOTS-1:0] m;
    case (filled)
      2'd1:    m = 4'b0001;
      2'd2:    m = 4'b0011;
      2'd3:    m = 4'b0111;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lpif_idle_flush_timer.sv
// Saturating count of consecutive idle cycles while a bundle is partially filled;
// raises hit_o on the idle cycle that reaches the programmed timeout.
module lpif_idle_flush_timer #(
  parameter int FLUSH_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               arm_i,
  input  logic               beat_i,
  input  logic [FLUSH_W-1:0] timeout_i,
  output logic               hit_o
);

  logic [FLUSH_W-1:0] cnt_q, cnt_d;
  logic [FLUSH_W-1:0] cnt_inc;

  // Count includes the current idle cycle; saturate rather than wrap; zero timeout never fires.
  always_comb begin
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    hit_o   = arm_i && !beat_i && (timeout_i != '0) && (cnt_inc >= timeout_i);
    cnt_d   = (!arm_i || beat_i || hit_o) ? '0 : cnt_inc;
  end

  // Idle counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lpif_dstrm_quarter_packer.sv
// Packs single-lane LPIF beats into four-slot bundles for the quarter-rate
// downstream top; supports idle-timeout partial flush and offline discard.
module lpif_dstrm_quarter_packer
  import lpif_quarter_pkg::*;
#(
  parameter int FLUSH_W = 8
) (
  input  logic                              clk_wr,
  input  logic                              rst_wr,
  input  logic                              tx_online,
  input  logic [FLUSH_W-1:0]                flush_timeout,
  input  logic                              in_valid,
  input  logic [SLOT_STATE_W-1:0]           in_state,
  input  logic [SLOT_PROTID_W-1:0]          in_protid,
  input  logic [SLOT_DATA_W-1:0]            in_data,
  input  logic                              in_dvalid,
  input  logic [SLOT_CRC_W-1:0]             in_crc,
  input  logic                              in_crc_valid,
  output logic [SLOTS*SLOT_STATE_W-1:0]     dstrm_state,
  output logic [SLOTS*SLOT_PROTID_W-1:0]    dstrm_protid,
  output logic [SLOTS*SLOT_DATA_W-1:0]      dstrm_data,
  output logic [SLOTS-1:0]                  dstrm_dvalid,
  output logic [SLOTS*SLOT_CRC_W-1:0]       dstrm_crc,
  output logic [SLOTS-1:0]                  dstrm_crc_valid,
  output logic [SLOTS-1:0]                  dstrm_valid,
  output logic [15:0]                       bundle_cnt,
  output logic [15:0]                       discard_cnt
);

  pack_state_e                  state_q, state_d;
  logic [SLOT_IDX_W-1:0]        slot_q, slot_d;

  logic [SLOTS*SLOT_DATA_W-1:0]   acc_data_q,   acc_data_d;
  logic [SLOTS*SLOT_STATE_W-1:0]  acc_state_q,  acc_state_d;
  logic [SLOTS*SLOT_PROTID_W-1:0] acc_protid_q, acc_protid_d;
  logic [SLOTS*SLOT_CRC_W-1:0]    acc_crc_q,    acc_crc_d;
  logic [SLOTS-1:0]               acc_dvalid_q, acc_dvalid_d;
  logic [SLOTS-1:0]               acc_crcv_q,   acc_crcv_d;

  logic [SLOTS*SLOT_DATA_W-1:0]   out_data_q,   out_data_d;
  logic [SLOTS*SLOT_STATE_W-1:0]  out_state_q,  out_state_d;
  logic [SLOTS*SLOT_PROTID_W-1:0] out_protid_q, out_protid_d;
  logic [SLOTS*SLOT_CRC_W-1:0]    out_crc_q,    out_crc_d;
  logic [SLOTS-1:0]               out_dvalid_q, out_dvalid_d;
  logic [SLOTS-1:0]               out_crcv_q,   out_crcv_d;
  logic [SLOTS-1:0]               out_valid_q,  out_valid_d;

  logic [15:0]                  bcnt_q, bcnt_d;
  logic [15:0]                  dcnt_q, dcnt_d;

  logic                         wr_en;
  logic                         emit;
  logic [SLOTS-1:0]             emit_mask;
  logic [2:0]                   discard_inc;
  logic                         flush_arm;
  logic                         flush_hit;

  assign flush_arm = (state_q == ST_FILL) && tx_online;

  lpif_idle_flush_timer #(
    .FLUSH_W (FLUSH_W)
  ) u_idle_flush_timer (
    .clk_i     (clk_wr),
    .rst_i     (rst_wr),
    .arm_i     (flush_arm),
    .beat_i    (in_valid),
    .timeout_i (flush_timeout),
    .hit_o     (flush_hit)
  );

  // FSM next state: offline handling, slot writes, complete emit and idle flush.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    wr_en       = 1'b0;
    emit        = 1'b0;
    emit_mask   = '0;
    discard_inc = 3'd0;
    case (state_q)
      ST_OFFLINE: begin
        slot_d      = '0;
        discard_inc = {2'b00, in_valid};
        if (tx_online) state_d = ST_IDLE;
      end
      ST_IDLE, ST_FILL: begin
        if (!tx_online) begin
          // Link loss drops the partial bundle plus any beat arriving now.
          state_d     = ST_OFFLINE;
          slot_d      = '0;
          discard_inc = {1'b0, slot_q} + {2'b00, in_valid};
        end else if (in_valid) begin
          wr_en  = 1'b1;
          slot_d = slot_q + 2'd1;
          if (slot_q == 2'd3) begin
            emit      = 1'b1;
            emit_mask = fill_mask(2'd0);
            state_d   = ST_IDLE;
          end else begin
            state_d   = ST_FILL;
          end
        end else if (flush_hit) begin
          emit      = 1'b1;
          emit_mask = fill_mask(slot_q);
          slot_d    = '0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_OFFLINE;
        slot_d  = '0;
      end
    endcase
  end

  // Accumulator update: the current beat lands in the slot picked by the slot counter.
  always_comb begin
    acc_data_d   = acc_data_q;
    acc_state_d  = acc_state_q;
    acc_protid_d = acc_protid_q;
    acc_crc_d    = acc_crc_q;
    acc_dvalid_d = acc_dvalid_q;
    acc_crcv_d   = acc_crcv_q;
    if (wr_en) begin
      acc_data_d  [int'(slot_q)*SLOT_DATA_W   +: SLOT_DATA_W]   = in_data;
      acc_state_d [int'(slot_q)*SLOT_STATE_W  +: SLOT_STATE_W]  = in_state;
      acc_protid_d[int'(slot_q)*SLOT_PROTID_W +: SLOT_PROTID_W] = in_protid;
      acc_crc_d   [int'(slot_q)*SLOT_CRC_W    +: SLOT_CRC_W]    = in_crc;
      acc_dvalid_d[slot_q] = in_dvalid;
      acc_crcv_d  [slot_q] = in_crc_valid;
    end
  end

  // Output staging: copy only filled slots of an emitted bundle, zero everything otherwise.
  always_comb begin
    out_data_d   = '0;
    out_state_d  = '0;
    out_protid_d = '0;
    out_crc_d    = '0;
    out_dvalid_d = '0;
    out_crcv_d   = '0;
    out_valid_d  = '0;
    if (emit) begin
      out_valid_d = emit_mask;
      for (int i = 0; i < SLOTS; i++) begin
        if (emit_mask[i]) begin
          out_data_d  [i*SLOT_DATA_W   +: SLOT_DATA_W]   = acc_data_d  [i*SLOT_DATA_W   +: SLOT_DATA_W];
          out_state_d [i*SLOT_STATE_W  +: SLOT_STATE_W]  = acc_state_d [i*SLOT_STATE_W  +: SLOT_STATE_W];
          out_protid_d[i*SLOT_PROTID_W +: SLOT_PROTID_W] = acc_protid_d[i*SLOT_PROTID_W +: SLOT_PROTID_W];
          out_crc_d   [i*SLOT_CRC_W    +: SLOT_CRC_W]    = acc_crc_d   [i*SLOT_CRC_W    +: SLOT_CRC_W];
          out_dvalid_d[i] = acc_dvalid_d[i];
          out_crcv_d  [i] = acc_crcv_d[i];
        end
      end
    end
    bcnt_d = bcnt_q + {15'd0, emit};
    dcnt_d = dcnt_q + {13'd0, discard_inc};
  end

  // State, accumulator, output and counter registers.
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      state_q      <= ST_OFFLINE;
      slot_q       <= '0;
      acc_data_q   <= '0;
      acc_state_q  <= '0;
      acc_protid_q <= '0;
      acc_crc_q    <= '0;
      acc_dvalid_q <= '0;
      acc_crcv_q   <= '0;
      out_data_q   <= '0;
      out_state_q  <= '0;
      out_protid_q <= '0;
      out_crc_q    <= '0;
      out_dvalid_q <= '0;
      out_crcv_q   <= '0;
      out_valid_q  <= '0;
      bcnt_q       <= '0;
      dcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      acc_data_q   <= acc_data_d;
      acc_state_q  <= acc_state_d;
      acc_protid_q <= acc_protid_d;
      acc_crc_q    <= acc_crc_d;
      acc_dvalid_q <= acc_dvalid_d;
      acc_crcv_q   <= acc_crcv_d;
      out_data_q   <= out_data_d;
      out_state_q  <= out_state_d;
      out_protid_q <= out_protid_d;
      out_crc_q    <= out_crc_d;
      out_dvalid_q <= out_dvalid_d;
      out_crcv_q   <= out_crcv_d;
      out_valid_q  <= out_valid_d;
      bcnt_q       <= bcnt_d;
      dcnt_q       <= dcnt_d;
    end
  end

  assign dstrm_data      = out_data_q;
  assign dstrm_state     = out_state_q;
  assign dstrm_protid    = out_protid_q;
  assign dstrm_crc       = out_crc_q;
  assign dstrm_dvalid    = out_dvalid_q;
  assign dstrm_crc_valid = out_crcv_q;
  assign dstrm_valid     = out_valid_q;
  assign bundle_cnt      = bcnt_q;
  assign discard_cnt     = dcnt_q;

endmodule

// File: tb/tb_lpif_dstrm_quarter_packer.sv
// Directed bench for the quarter-rate packer: a per-cycle vector table plus
// hand-written sequences for flush, full-slot mapping and reset corners.
module tb_lpif_dstrm_quarter_packer;

  logic          clk_wr = 1'b0;
  logic          rst_wr;
  logic          tx_online;
  logic [7:0]    flush_timeout;
  logic          in_valid;
  logic [3:0]    in_state;
  logic [1:0]    in_protid;
  logic [255:0]  in_data;
  logic          in_dvalid;
  logic [15:0]   in_crc;
  logic          in_crc_valid;
  logic [15:0]   dstrm_state;
  logic [7:0]    dstrm_protid;
  logic [1023:0] dstrm_data;
  logic [3:0]    dstrm_dvalid;
  logic [63:0]   dstrm_crc;
  logic [3:0]    dstrm_crc_valid;
  logic [3:0]    dstrm_valid;
  logic [15:0]   bundle_cnt;
  logic [15:0]   discard_cnt;

  int total = 0;
  int bad   = 0;

  lpif_dstrm_quarter_packer #(.FLUSH_W(8)) dut (
    .clk_wr          (clk_wr),
    .rst_wr          (rst_wr),
    .tx_online       (tx_online),
    .flush_timeout   (flush_timeout),
    .in_valid        (in_valid),
    .in_state        (in_state),
    .in_protid       (in_protid),
    .in_data         (in_data),
    .in_dvalid       (in_dvalid),
    .in_crc          (in_crc),
    .in_crc_valid    (in_crc_valid),
    .dstrm_state     (dstrm_state),
    .dstrm_protid    (dstrm_protid),
    .dstrm_data      (dstrm_data),
    .dstrm_dvalid    (dstrm_dvalid),
    .dstrm_crc       (dstrm_crc),
    .dstrm_crc_valid (dstrm_crc_valid),
    .dstrm_valid     (dstrm_valid),
    .bundle_cnt      (bundle_cnt),
    .discard_cnt     (discard_cnt)
  );

  always #5 clk_wr = ~clk_wr;

  typedef struct {
    logic        online;
    logic        vld;
    logic [7:0]  fto;
    logic [7:0]  dat;
    logic [3:0]  exp_vld;
    logic [7:0]  exp_d0;
    logic [15:0] exp_bcnt;
    logic [15:0] exp_dcnt;
  } vec_t;

  vec_t tbl [27];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Beat fields are all derived from one byte so each slot is identifiable.
  task automatic drive(input logic online, input logic vld, input logic [7:0] b);
    tx_online    = online;
    in_valid     = vld;
    in_data      = {248'd0, b};
    in_state     = b[3:0];
    in_protid    = b[5:4];
    in_crc       = {b, ~b};
    in_dvalid    = vld;
    in_crc_valid = vld & b[0];
  endtask

  task automatic tick();
    @(posedge clk_wr);
    #1;
  endtask

  task automatic check_bundle(input string tag, input logic [3:0] mask,
                              input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] bs [4];
    logic [7:0] b;
    bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
    chk({tag, "_valid"}, dstrm_valid, mask);
    for (int i = 0; i < 4; i++) begin
      b = mask[i] ? bs[i] : 8'd0;
      chk($sformatf("%s_data%0d", tag, i), dstrm_data[256*i +: 256], {248'd0, b});
      chk($sformatf("%s_state%0d", tag, i), dstrm_state[4*i +: 4], b[3:0]);
      chk($sformatf("%s_protid%0d", tag, i), dstrm_protid[2*i +: 2], b[5:4]);
      chk($sformatf("%s_crc%0d", tag, i), dstrm_crc[16*i +: 16], mask[i] ? {b, ~b} : 16'd0);
      chk($sformatf("%s_dvalid%0d", tag, i), dstrm_dvalid[i], mask[i]);
      chk($sformatf("%s_crcv%0d", tag, i), dstrm_crc_valid[i], mask[i] & b[0]);
    end
  endtask

  initial begin
    int quiet;
    // online vld fto dat | exp_vld exp_d0 bcnt dcnt
    tbl[0]  = '{1'b0, 1'b1, 8'd0, 8'hAA, 4'h0, 8'h00, 16'd0, 16'd1};
    tbl[1]  = '{1'b1, 1'b0, 8'd0, 8'h00, 4'h0, 8'h00, 16'd0, 16'd1};
    tbl[2]  = '{1'b1, 1'b1, 8'd0, 8'h01, 4'h0, 8'h00, 16'd0, 16'd1};
    tbl[3]  = '{1'b1, 1'b1, 8'd0, 8'h02, 4'h0, 8'h00, 16'd0, 16'd1};
    tbl[4]  = '{1'b1, 1'b1, 8'd0, 8'h03, 4'h0, 8'h00, 16'd0, 16'd1};
    tbl[5]  = '{1'b1, 1'b1, 8'd0, 8'h04, 4'hF, 8'h01, 16'd1, 16'd1};
    tbl[6]  = '{1'b1, 1'b1, 8'd0, 8'h05, 4'h0, 8'h00, 16'd1, 16'd1};
    tbl[7]  = '{1'b1, 1'b1, 8'd0, 8'h06, 4'h0, 8'h00, 16'd1, 16'd1};
    tbl[8]  = '{1'b1, 1'b1, 8'd0, 8'h07, 4'h0, 8'h00, 16'd1, 16'd1};
    tbl[9]  = '{1'b1, 1'b1, 8'd0, 8'h08, 4'hF, 8'h05, 16'd2, 16'd1};
    tbl[10] = '{1'b1, 1'b1, 8'd3, 8'h09, 4'h0, 8'h00, 16'd2, 16'd1};
    tbl[11] = '{1'b1, 1'b1, 8'd3, 8'h0A, 4'h0, 8'h00, 16'd2, 16'd1};
    tbl[12] = '{1'b1, 1'b0, 8'd3, 8'h00, 4'h0, 8'h00, 16'd2, 16'd1};
    tbl[13] = '{1'b1, 1'b0, 8'd3, 8'h00, 4'h0, 8'h00, 16'd2, 16'd1};
    tbl[14] = '{1'b1, 1'b0, 8'd3, 8'h00, 4'h3, 8'h09, 16'd3, 16'd1};
    tbl[15] = '{1'b1, 1'b0, 8'd3, 8'h00, 4'h0, 8'h00, 16'd3, 16'd1};
    tbl[16] = '{1'b1, 1'b1, 8'd0, 8'h0B, 4'h0, 8'h00, 16'd3, 16'd1};
    tbl[17] = '{1'b1, 1'b1, 8'd0, 8'h0C, 4'h0, 8'h00, 16'd3, 16'd1};
    tbl[18] = '{1'b1, 1'b1, 8'd0, 8'h0D, 4'h0, 8'h00, 16'd3, 16'd1};
    tbl[19] = '{1'b0, 1'b0, 8'd0, 8'h00, 4'h0, 8'h00, 16'd3, 16'd4};
    tbl[20] = '{1'b0, 1'b1, 8'd0, 8'hEE, 4'h0, 8'h00, 16'd3, 16'd5};
    tbl[21] = '{1'b1, 1'b1, 8'd0, 8'hEF, 4'h0, 8'h00, 16'd3, 16'd6};
    tbl[22] = '{1'b1, 1'b1, 8'd0, 8'h10, 4'h0, 8'h00, 16'd3, 16'd6};
    tbl[23] = '{1'b1, 1'b1, 8'd0, 8'h11, 4'h0, 8'h00, 16'd3, 16'd6};
    tbl[24] = '{1'b1, 1'b1, 8'd0, 8'h12, 4'h0, 8'h00, 16'd3, 16'd6};
    tbl[25] = '{1'b0, 1'b1, 8'd0, 8'h13, 4'h0, 8'h00, 16'd3, 16'd10};
    tbl[26] = '{1'b1, 1'b0, 8'd0, 8'h00, 4'h0, 8'h00, 16'd3, 16'd10};

    // Reset state
    rst_wr = 1'b1;
    flush_timeout = 8'd0;
    drive(1'b0, 1'b0, 8'h00);
    tick();
    tick();
    check_bundle("rst", 4'h0, 8'h0, 8'h0, 8'h0, 8'h0);
    chk("rst_bcnt", bundle_cnt, 16'd0);
    chk("rst_dcnt", discard_cnt, 16'd0);
    rst_wr = 1'b0;

    // Per-cycle vector table
    for (int v = 0; v < 27; v++) begin
      flush_timeout = tbl[v].fto;
      drive(tbl[v].online, tbl[v].vld, tbl[v].dat);
      tick();
      chk($sformatf("vec%0d_valid", v), dstrm_valid, tbl[v].exp_vld);
      chk($sformatf("vec%0d_d0", v), dstrm_data[255:0], {248'd0, tbl[v].exp_d0});
      chk($sformatf("vec%0d_bcnt", v), bundle_cnt, tbl[v].exp_bcnt);
      chk($sformatf("vec%0d_dcnt", v), discard_cnt, tbl[v].exp_dcnt);
    end

    // Flush disabled: one beat then a long idle stretch stays silent
    flush_timeout = 8'd0;
    drive(1'b1, 1'b1, 8'h21);
    tick();
    quiet = 0;
    drive(1'b1, 1'b0, 8'h00);
    for (int c = 0; c < 100; c++) begin
      tick();
      if (dstrm_valid !== 4'h0) quiet++;
    end
    chk("noflush_quiet", quiet, 0);
    drive(1'b1, 1'b1, 8'h22); tick();
    drive(1'b1, 1'b1, 8'h23); tick();
    drive(1'b1, 1'b1, 8'h24); tick();
    check_bundle("full", 4'hF, 8'h21, 8'h22, 8'h23, 8'h24);
    chk("full_bcnt", bundle_cnt, 16'd4);
    drive(1'b1, 1'b0, 8'h00); tick();
    check_bundle("after_full", 4'h0, 8'h0, 8'h0, 8'h0, 8'h0);

    // Two-slot partial flush with timeout 3
    flush_timeout = 8'd3;
    drive(1'b1, 1'b1, 8'h31); tick();
    drive(1'b1, 1'b1, 8'h32); tick();
    drive(1'b1, 1'b0, 8'h00);
    tick(); chk("part_wait1", dstrm_valid, 4'h0);
    tick(); chk("part_wait2", dstrm_valid, 4'h0);
    tick(); check_bundle("partial", 4'h3, 8'h31, 8'h32, 8'h00, 8'h00);
    chk("partial_bcnt", bundle_cnt, 16'd5);
    tick(); chk("partial_once", dstrm_valid, 4'h0);

    // Three-slot partial flush with timeout 1
    flush_timeout = 8'd1;
    drive(1'b1, 1'b1, 8'h61); tick();
    drive(1'b1, 1'b1, 8'h62); tick();
    drive(1'b1, 1'b1, 8'h63); tick();
    drive(1'b1, 1'b0, 8'h00); tick();
    check_bundle("partial3", 4'h7, 8'h61, 8'h62, 8'h63, 8'h00);
    chk("partial3_bcnt", bundle_cnt, 16'd6);

    // Reset mid-fill, then a clean bundle
    flush_timeout = 8'd0;
    drive(1'b1, 1'b1, 8'h41); tick();
    drive(1'b1, 1'b1, 8'h42); tick();
    drive(1'b1, 1'b0, 8'h00);
    rst_wr = 1'b1;
    tick();
    rst_wr = 1'b0;
    check_bundle("midrst", 4'h0, 8'h0, 8'h0, 8'h0, 8'h0);
    chk("midrst_bcnt", bundle_cnt, 16'd0);
    chk("midrst_dcnt", discard_cnt, 16'd0);
    tick();
    drive(1'b1, 1'b1, 8'h51); tick();
    drive(1'b1, 1'b1, 8'h52); tick();
    drive(1'b1, 1'b1, 8'h53); tick();
    drive(1'b1, 1'b1, 8'h54); tick();
    check_bundle("post_rst", 4'hF, 8'h51, 8'h52, 8'h53, 8'h54);
    chk("post_rst_bcnt", bundle_cnt, 16'd1);
    chk("post_rst_dcnt", discard_cnt, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
